// File: rtl/cond_pkg.sv
// Shared constants for the ARM condition unit: condition-code encodings and
// the bit positions of N/Z/C/V inside the packed flag nibble.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] flags_t;

endpackage

// File: rtl/cond_eval.sv
// Pure combinational condition check: a 4-bit ARM condition field evaluated
// against a {N,Z,C,V} nibble. Also used by the branch predictor check.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            COND_NV: CondEx = 1'b0;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit_pipe.sv
// Execute-stage condition unit: gates write enables on the condition result,
// owns the architectural flags, an exception flag shadow stack and
// saturating executed/squashed counters.
module cond_unit_pipe
    import cond_pkg::*;
#(
    parameter int SHADOW_DEPTH = 2,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Valid_E,
    input  logic             Stall_E,
    input  logic             Flush_E,
    input  logic [3:0]       Cond_E,
    input  logic [1:0]       FlagW_E,
    input  logic             PCS_E,
    input  logic             RegW_E,
    input  logic             MemW_E,
    input  logic             NoWrite_E,
    input  logic [3:0]       ALUFlags,
    input  logic             ExcEntry,
    input  logic             ExcReturn,
    output logic             PCSrc_E,
    output logic             RegWrite_E,
    output logic             MemWrite_E,
    output logic             CondEx_E,
    output logic [3:0]       Flags,
    output logic             ShadowFull,
    output logic             ShadowEmpty,
    output logic             ShadowErr,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SquashCount
);

    localparam int PTR_W = $clog2(SHADOW_DEPTH + 1);

    flags_t             flags_q, flags_d;
    flags_t             aluNext;
    flags_t             topEntry;
    flags_t             stack_q [SHADOW_DEPTH];
    flags_t             stack_d [SHADOW_DEPTH];
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   exec_q, exec_d;
    logic [CNT_W-1:0]   squash_q, squash_d;

    logic condEx, go, full, empty;
    logic entryOnly, returnOnly, pushOk, popOk, misuse;

    cond_eval u_eval (
        .Cond   (Cond_E),
        .Flags  (flags_q),
        .CondEx (condEx)
    );

    assign go          = Valid_E & ~Stall_E & ~Flush_E & ~RESET;
    assign full        = (ptr_q == PTR_W'(SHADOW_DEPTH));
    assign empty       = (ptr_q == '0);
    assign entryOnly   = ExcEntry & ~ExcReturn;
    assign returnOnly  = ExcReturn & ~ExcEntry;
    assign pushOk      = entryOnly & ~full;
    assign popOk       = returnOnly & ~empty;
    assign misuse      = (entryOnly & full) | (returnOnly & empty) | (ExcEntry & ExcReturn);

    always_comb begin
        topEntry = '0;
        for (int i = 0; i < SHADOW_DEPTH; i++) begin
            if (ptr_q == PTR_W'(i + 1)) topEntry = stack_q[i];
        end
    end

    // A push captures the flags including this cycle's ALU update; a pop wins over it.
    always_comb begin
        aluNext = flags_q;
        if (go && condEx) begin
            if (FlagW_E[1]) begin
                aluNext[FLAG_N] = ALUFlags[FLAG_N];
                aluNext[FLAG_Z] = ALUFlags[FLAG_Z];
            end
            if (FlagW_E[0]) begin
                aluNext[FLAG_C] = ALUFlags[FLAG_C];
                aluNext[FLAG_V] = ALUFlags[FLAG_V];
            end
        end
        flags_d = popOk ? topEntry : aluNext;
        stack_d = stack_q;
        ptr_d   = ptr_q;
        for (int i = 0; i < SHADOW_DEPTH; i++) begin
            if (pushOk && ptr_q == PTR_W'(i)) stack_d[i] = aluNext;
        end
        if (pushOk) ptr_d = ptr_q + 1'b1;
        else if (popOk) ptr_d = ptr_q - 1'b1;
        err_d = err_q | misuse;
    end

    always_comb begin
        exec_d   = exec_q;
        squash_d = squash_q;
        if (go && condEx && exec_q != '1) exec_d = exec_q + 1'b1;
        if (go && !condEx && squash_q != '1) squash_d = squash_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            flags_q  <= '0;
            ptr_q    <= '0;
            err_q    <= 1'b0;
            exec_q   <= '0;
            squash_q <= '0;
            for (int i = 0; i < SHADOW_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            flags_q  <= flags_d;
            ptr_q    <= ptr_d;
            err_q    <= err_d;
            exec_q   <= exec_d;
            squash_q <= squash_d;
            for (int i = 0; i < SHADOW_DEPTH; i++) stack_q[i] <= stack_d[i];
        end
    end

    assign CondEx_E    = condEx & ~RESET;
    assign PCSrc_E     = go & condEx & PCS_E;
    assign RegWrite_E  = go & condEx & RegW_E & ~NoWrite_E;
    assign MemWrite_E  = go & condEx & MemW_E;
    assign Flags       = flags_q;
    assign ShadowFull  = full;
    assign ShadowEmpty = empty;
    assign ShadowErr   = err_q;
    assign ExecCount   = exec_q;
    assign SquashCount = squash_q;

endmodule

// File: tb/tb_cond_unit_pipe.sv
// Directed bench for cond_unit_pipe: vector table for the pipeline behaviour
// plus hand-written sequences for decode, shadow stack and counter corners.
module tb_cond_unit_pipe;

    logic       CLK, RESET;
    logic       Valid_E, Stall_E, Flush_E;
    logic [3:0] Cond_E;
    logic [1:0] FlagW_E;
    logic       PCS_E, RegW_E, MemW_E, NoWrite_E;
    logic [3:0] ALUFlags;
    logic       ExcEntry, ExcReturn;
    logic       PCSrc_E, RegWrite_E, MemWrite_E, CondEx_E;
    logic [3:0] Flags;
    logic       ShadowFull, ShadowEmpty, ShadowErr;
    logic [3:0] ExecCount, SquashCount;

    int errors = 0;
    int checks = 0;

    cond_unit_pipe #(.SHADOW_DEPTH(2), .CNT_W(4)) dut (
        .CLK(CLK), .RESET(RESET), .Valid_E(Valid_E), .Stall_E(Stall_E), .Flush_E(Flush_E),
        .Cond_E(Cond_E), .FlagW_E(FlagW_E), .PCS_E(PCS_E), .RegW_E(RegW_E), .MemW_E(MemW_E),
        .NoWrite_E(NoWrite_E), .ALUFlags(ALUFlags), .ExcEntry(ExcEntry), .ExcReturn(ExcReturn),
        .PCSrc_E(PCSrc_E), .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E), .CondEx_E(CondEx_E),
        .Flags(Flags), .ShadowFull(ShadowFull), .ShadowEmpty(ShadowEmpty), .ShadowErr(ShadowErr),
        .ExecCount(ExecCount), .SquashCount(SquashCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       valid, stall, flush;
        logic [3:0] cond;
        logic [1:0] flagW;
        logic       pcs, regw, memw, nowrite;
        logic [3:0] alu;
        logic       expCondEx, expPc, expReg, expMem;
        logic [3:0] expFlags;
    } vec_t;

    vec_t vecs [12];

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic stall, input logic flush,
                                 input logic [3:0] cond, input logic [1:0] flagW,
                                 input logic pcs, input logic regw, input logic memw,
                                 input logic nowrite, input logic [3:0] alu);
        Valid_E = valid; Stall_E = stall; Flush_E = flush; Cond_E = cond; FlagW_E = flagW;
        PCS_E = pcs; RegW_E = regw; MemW_E = memw; NoWrite_E = nowrite; ALUFlags = alu;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 4'he, 2'b00, 0, 0, 0, 0, 4'h0);
        ExcEntry = 0; ExcReturn = 0;
    endtask

    task automatic setFlags(input logic [3:0] f);
        applyStimulus(1, 0, 0, 4'he, 2'b11, 0, 0, 0, 0, f);
        step();
        idle();
    endtask

    task automatic doReset();
        idle();
        RESET = 1;
        step();
        RESET = 0;
    endtask

    function automatic logic condRef(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cc, v;
        {n, z, cc, v} = f;
        case (c)
            4'h0: return z;              4'h1: return !z;
            4'h2: return cc;             4'h3: return !cc;
            4'h4: return n;              4'h5: return !n;
            4'h6: return v;              4'h7: return !v;
            4'h8: return cc && !z;       4'h9: return !cc || z;
            4'ha: return n == v;         4'hb: return n != v;
            4'hc: return !z && n == v;   4'hd: return z || n != v;
            4'he: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        //          v  s  f  cond   fw     pcs rw mw nw alu      cx pc rg mm flags
        vecs[0]  = '{1, 0, 0, 4'he, 2'b11, 0, 1, 0, 0, 4'b0110, 1, 0, 1, 0, 4'b0110};
        vecs[1]  = '{1, 0, 0, 4'h0, 2'b00, 0, 1, 0, 0, 4'b0000, 1, 0, 1, 0, 4'b0110};
        vecs[2]  = '{1, 0, 0, 4'h1, 2'b11, 1, 1, 1, 0, 4'b1111, 0, 0, 0, 0, 4'b0110};
        vecs[3]  = '{1, 0, 0, 4'h2, 2'b01, 1, 1, 1, 1, 4'b0001, 1, 1, 0, 1, 4'b0101};
        vecs[4]  = '{1, 1, 0, 4'he, 2'b11, 1, 1, 1, 0, 4'b1000, 1, 0, 0, 0, 4'b0101};
        vecs[5]  = '{1, 0, 1, 4'he, 2'b11, 1, 1, 1, 0, 4'b1000, 1, 0, 0, 0, 4'b0101};
        vecs[6]  = '{0, 0, 0, 4'he, 2'b11, 1, 1, 1, 0, 4'b1000, 1, 0, 0, 0, 4'b0101};
        vecs[7]  = '{1, 0, 0, 4'hc, 2'b10, 0, 1, 0, 0, 4'b1000, 0, 0, 0, 0, 4'b0101};
        vecs[8]  = '{1, 0, 0, 4'hd, 2'b10, 0, 1, 0, 0, 4'b1000, 1, 0, 1, 0, 4'b1001};
        vecs[9]  = '{1, 0, 0, 4'hb, 2'b11, 1, 1, 1, 0, 4'b0000, 0, 0, 0, 0, 4'b1001};
        vecs[10] = '{1, 0, 0, 4'ha, 2'b11, 1, 0, 0, 0, 4'b0000, 1, 1, 0, 0, 4'b0000};
        vecs[11] = '{1, 0, 0, 4'hf, 2'b11, 1, 1, 1, 0, 4'b1111, 0, 0, 0, 0, 4'b0000};

        idle();
        RESET = 1;
        applyStimulus(1, 0, 0, 4'he, 2'b11, 1, 1, 1, 0, 4'b1111);
        #1;
        checkOutput("rst_condex", CondEx_E, 0);
        checkOutput("rst_pcsrc", PCSrc_E, 0);
        checkOutput("rst_regw", RegWrite_E, 0);
        checkOutput("rst_memw", MemWrite_E, 0);
        step();
        step();
        idle();
        RESET = 0;
        #1;
        checkOutput("rst_flags", Flags, 4'h0);
        checkOutput("rst_empty", ShadowEmpty, 1);
        checkOutput("rst_full", ShadowFull, 0);
        checkOutput("rst_err", ShadowErr, 0);
        checkOutput("rst_exec", ExecCount, 0);
        checkOutput("rst_squash", SquashCount, 0);

        // Pipeline vector table: zero-latency enables, flags visible next cycle.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].stall, vecs[i].flush, vecs[i].cond, vecs[i].flagW,
                          vecs[i].pcs, vecs[i].regw, vecs[i].memw, vecs[i].nowrite, vecs[i].alu);
            #1;
            checkOutput($sformatf("vec%0d_condex", i), CondEx_E, vecs[i].expCondEx);
            checkOutput($sformatf("vec%0d_pcsrc", i), PCSrc_E, vecs[i].expPc);
            checkOutput($sformatf("vec%0d_regw", i), RegWrite_E, vecs[i].expReg);
            checkOutput($sformatf("vec%0d_memw", i), MemWrite_E, vecs[i].expMem);
            step();
            checkOutput($sformatf("vec%0d_flags", i), Flags, vecs[i].expFlags);
        end
        idle();
        checkOutput("vec_exec", ExecCount, 5);
        checkOutput("vec_squash", SquashCount, 4);

        // Decode sweep over every flag value and condition code.
        for (int f = 0; f < 16; f++) begin
            setFlags(4'(f));
            checkOutput($sformatf("sweep_flags%0d", f), Flags, 16'(f));
            Valid_E = 1;
            for (int c = 0; c < 16; c++) begin
                Cond_E = 4'(c);
                #1;
                checkOutput($sformatf("sweep_f%0d_c%0d", f, c), CondEx_E, condRef(4'(c), 4'(f)));
            end
            idle();
        end

        // Shadow stack fill, overflow, drain, underflow.
        doReset();
        setFlags(4'b1010);
        ExcEntry = 1; step(); ExcEntry = 0;
        setFlags(4'b0101);
        ExcEntry = 1; step(); ExcEntry = 0;
        checkOutput("stk_full", ShadowFull, 1);
        checkOutput("stk_err_before", ShadowErr, 0);
        ExcEntry = 1; step(); ExcEntry = 0;
        checkOutput("stk_overflow_err", ShadowErr, 1);
        checkOutput("stk_overflow_flags", Flags, 4'b0101);
        setFlags(4'b0000);
        ExcReturn = 1; step();
        checkOutput("stk_pop1", Flags, 4'b0101);
        checkOutput("stk_notfull", ShadowFull, 0);
        step();
        checkOutput("stk_pop2", Flags, 4'b1010);
        checkOutput("stk_empty", ShadowEmpty, 1);
        step(); ExcReturn = 0;
        checkOutput("stk_underflow_flags", Flags, 4'b1010);
        checkOutput("stk_err_sticky", ShadowErr, 1);

        // Simultaneous exception and ALU events.
        doReset();
        applyStimulus(1, 0, 0, 4'he, 2'b11, 0, 0, 0, 0, 4'b1001);
        ExcEntry = 1; step(); idle();
        checkOutput("sim_push_flags", Flags, 4'b1001);
        checkOutput("sim_push_empty", ShadowEmpty, 0);
        setFlags(4'b0011);
        applyStimulus(1, 0, 0, 4'he, 2'b11, 0, 0, 0, 0, 4'b1111);
        ExcReturn = 1; step(); idle();
        checkOutput("sim_pop_flags", Flags, 4'b1001);
        checkOutput("sim_pop_empty", ShadowEmpty, 1);
        checkOutput("sim_err_clear", ShadowErr, 0);
        ExcEntry = 1; ExcReturn = 1; step(); idle();
        checkOutput("sim_both_err", ShadowErr, 1);
        checkOutput("sim_both_empty", ShadowEmpty, 1);
        checkOutput("sim_both_flags", Flags, 4'b1001);

        // Stack still serviced during a stall; flags and counters frozen otherwise.
        doReset();
        setFlags(4'b1100);
        applyStimulus(1, 1, 0, 4'he, 2'b11, 1, 1, 1, 0, 4'b0011);
        ExcEntry = 1; step(); ExcEntry = 0;
        checkOutput("stall_flags", Flags, 4'b1100);
        checkOutput("stall_push", ShadowEmpty, 0);
        checkOutput("stall_exec", ExecCount, 1);

        // Counter saturation and mid-run reset.
        doReset();
        applyStimulus(1, 0, 0, 4'he, 2'b00, 0, 0, 0, 0, 4'h0);
        for (int i = 0; i < 20; i++) step();
        checkOutput("sat_exec", ExecCount, 15);
        checkOutput("sat_squash0", SquashCount, 0);
        Cond_E = 4'hf;
        for (int i = 0; i < 3; i++) step();
        checkOutput("sat_squash3", SquashCount, 3);
        checkOutput("sat_exec_hold", ExecCount, 15);
        setFlags(4'b0110);
        ExcEntry = 1; step(); ExcEntry = 0; ExcReturn = 1; ExcEntry = 1; step();
        applyStimulus(1, 0, 0, 4'he, 2'b11, 1, 1, 1, 0, 4'b1111);
        ExcEntry = 1; ExcReturn = 0;
        RESET = 1; step(); RESET = 0; idle();
        checkOutput("mid_rst_flags", Flags, 4'h0);
        checkOutput("mid_rst_empty", ShadowEmpty, 1);
        checkOutput("mid_rst_err", ShadowErr, 0);
        checkOutput("mid_rst_exec", ExecCount, 0);
        checkOutput("mid_rst_squash", SquashCount, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cond_unit_pipe.md
# cond_unit_pipe

Parametrised condition unit for the pipelined ARM datapath, sitting in the Execute stage between the decoder's control bits and the register file, memory and PC-select write enables. It evaluates the 4-bit condition field against the architectural N/Z/C/V flags, gates the write enables, and updates the flags under stall and flush control. It also keeps a flag shadow stack for exception entry and return, plus saturating executed/squashed instruction counters for performance monitoring.

## Interface
- SHADOW_DEPTH, 2, number of flag-save entries in the exception shadow stack (>=1)
- CNT_W, 16, width of the statistics counters
- CLK  in  1  clock, rising edge
- RESET  in  1  synchronous, active-high reset
- Valid_E  in  1  Execute stage holds a real instruction
- Stall_E  in  1  Execute stage is held this cycle
- Flush_E  in  1  Execute instruction is squashed this cycle
- Cond_E  in  4  condition field
- FlagW_E  in  2  [1]=update N,Z; [0]=update C,V
- PCS_E, RegW_E, MemW_E, NoWrite_E  in  1 each  decoder controls
- ALUFlags  in  4  {N,Z,C,V} from the ALU
- ExcEntry  in  1  push flags to the shadow stack
- ExcReturn  in  1  pop flags from the shadow stack
- PCSrc_E, RegWrite_E, MemWrite_E  out  1 each  gated enables
- CondEx_E  out  1  condition passed
- Flags  out  4  architectural {N,Z,C,V}
- ShadowFull, ShadowEmpty  out  1 each  stack status
- ShadowErr  out  1  sticky stack misuse flag
- ExecCount, SquashCount  out  CNT_W each  statistics

## Operation
- Go = Valid_E & ~Stall_E & ~Flush_E & ~RESET.
- CondEx_E is decoded from Cond_E against the Flags register:
  - 0000 EQ Z; 0001 NE ~Z
  - 0010 CS C; 0011 CC ~C
  - 0100 MI N; 0101 PL ~N
  - 0110 VS V; 0111 VC ~V
  - 1000 HI C&~Z; 1001 LS ~C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 0
- PCSrc_E = Go&CondEx_E&PCS_E.
- RegWrite_E = Go&CondEx_E&RegW_E&~NoWrite_E.
- MemWrite_E = Go&CondEx_E&MemW_E.
- Flag update when Go&CondEx_E: N,Z <= ALUFlags[3:2] if FlagW_E[1]; C,V <= ALUFlags[1:0] if FlagW_E[0]. Otherwise the flags hold.
- Shadow stack (not affected by Stall_E or Flush_E):
  - ExcEntry alone, not full: push the next-state flags (including this cycle's ALU update).
  - ExcReturn alone, not empty: Flags <= top entry and pop. The pop overrides any ALU update in the same cycle.
  - Push when full or pop when empty: no stack or flag change from the request; ShadowErr <= 1.
  - ExcEntry&ExcReturn together: both ignored; ShadowErr <= 1.
  - ShadowErr stays set until RESET.
- Counters:
  - ExecCount += 1 on Go&CondEx_E.
  - SquashCount += 1 on Go&~CondEx_E.
  - Both saturate at all-ones. Flushed, stalled or invalid cycles are not counted.

## Timing
- Enables and CondEx_E are combinational from the inputs and Flags in the same cycle; zero latency.
- Flag updates, pushes and pops become visible on Flags one cycle after the edge.
- A back-to-back dependent instruction sees the updated flags, so no bypass is needed.
- Reset values:
  - Flags=0000, stack empty (ShadowEmpty=1, ShadowFull=0), ShadowErr=0, counters=0.
  - All gated enables and CondEx_E are forced to 0 while RESET is high.
- RESET mid-operation discards the stack contents and any pending update in that cycle.
- Stall_E=1 freezes the flags and counters. The stack still services exceptions.

## Structure
- Package cond_pkg holds:
  - the 4-bit condition-code localparams (EQ..AL, NV)
  - the flag bit indices (N=3, Z=2, C=1, V=0)
- Sub-module cond_eval is purely combinational: Cond and {N,Z,C,V} in, CondEx out. It is reused by the branch predictor check.
- The shadow stack is an array of SHADOW_DEPTH x 4 bits with a pointer of $clog2(SHADOW_DEPTH+1) bits.

## Test plan
- Decode sweep: for each of the 16 Flags values x 16 Cond codes with Valid_E=1, CondEx_E matches the table. Cond=1111 always gives 0; Cond=1110 always gives 1.
- Flag update: Flags=0000, Cond=1110, FlagW_E=11, ALUFlags=0110 gives Flags=0110 next cycle. Then Cond=0000 (EQ) gives RegWrite_E=1 with RegW_E=1, NoWrite_E=0.
- Stall/flush: with a passing condition and FlagW_E=11, Stall_E=1 or Flush_E=1 gives all enables 0, Flags unchanged and counters unchanged.
- Shadow stack, SHADOW_DEPTH=2:
  - Push 1010, then push 0101; ShadowFull=1.
  - A third push sets ShadowErr=1.
  - Two pops restore 0101 then 1010, and ShadowEmpty=1.
  - A further pop leaves Flags unchanged.
- Simultaneous events:
  - ExcEntry with a concurrent ALU update of 1001 pushes 1001.
  - ExcReturn concurrent with FlagW_E=11 leaves Flags equal to the popped value.
  - ExcEntry&ExcReturn together sets ShadowErr.
- Counter saturation: with CNT_W=4, 20 executed cycles give ExecCount=15. 3 failing-condition cycles give SquashCount=3. RESET mid-run clears everything to the reset values next cycle.
